// File: rtl/banco_registros_param.sv
// Parameterised register file with byte-enable write-back, write-to-read forwarding
// and a per-register reservation scoreboard (busy bits, population count, sticky error).
module banco_registros_param #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 32,
    parameter  int NUM_READ = 2,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    output logic [NUM_READ-1:0]          rd_busy,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [DATA_W/8-1:0]          wr_be,
    input  logic                         rsv_en,
    input  logic [ADDR_W-1:0]            rsv_addr,
    output logic [ADDR_W:0]              busy_count,
    output logic                         rsv_err
);

    localparam int NUM_BYTES = DATA_W / 8;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [DATA_W-1:0]   wr_merged;
    logic                wr_ok;
    logic                rsv_ok;
    logic                rsv_same;
    logic                cnt_inc;
    logic                cnt_dec;
    logic                err_set;
    logic [ADDR_W-1:0]   rd_sel;
    logic                rd_fwd;

    assign wr_ok    = wr_en && (wr_addr != '0);
    assign rsv_ok   = rsv_en && (rsv_addr != '0);
    assign rsv_same = wr_ok && (wr_addr == rsv_addr);

    // A reservation landing on a register cleared by the same-cycle write counts as
    // a fresh reservation: net count change is zero and no error is flagged.
    assign cnt_inc = rsv_ok && (!busy[rsv_addr] || rsv_same);
    assign cnt_dec = wr_ok && busy[wr_addr];
    assign err_set = rsv_ok && busy[rsv_addr] && !rsv_same;

    always_comb begin
        wr_merged = regs[wr_addr];
        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
            if (wr_be[b]) wr_merged[b*8 +: 8] = wr_data[b*8 +: 8];
        end
    end

    always_comb begin
        busy_next = busy;
        if (wr_ok)  busy_next[wr_addr]  = 1'b0;
        if (rsv_ok) busy_next[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_merged;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            busy_count <= '0;
            rsv_err    <= 1'b0;
        end else begin
            busy       <= busy_next;
            busy_count <= busy_count + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
            if (err_set) rsv_err <= 1'b1;
        end
    end

    // Outputs are gated by reset so a write presented during reset cannot forward.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_sel  = '0;
        rd_fwd  = 1'b0;
        for (int unsigned k = 0; k < NUM_READ; k++) begin
            rd_sel = rd_addr[k*ADDR_W +: ADDR_W];
            rd_fwd = wr_ok && (wr_addr == rd_sel);
            if (reset && (rd_sel != '0)) begin
                rd_data[k*DATA_W +: DATA_W] = rd_fwd ? wr_merged : regs[rd_sel];
                rd_busy[k]                  = busy[rd_sel] && !rd_fwd;
            end
        end
    end

endmodule

// File: tb/tb_banco_registros_param.sv
// Directed bench driving two configurations of banco_registros_param in lockstep;
// expectations come from a behavioural model and pass through a scoreboard queue.
module tb_banco_registros_param;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic        rsv_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [4:0]  rsv_addr = '0;
    logic [63:0] wr_data = '0;
    logic [7:0]  wr_be = '0;
    logic [4:0]  rd_a [4] = '{default: '0};

    logic [9:0]   a_rd_addr;
    logic [63:0]  a_rd_data;
    logic [1:0]   a_rd_busy;
    logic [5:0]   a_busy_count;
    logic         a_rsv_err;
    logic [15:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic [4:0]   b_busy_count;
    logic         b_rsv_err;

    always #5 clock = ~clock;

    assign a_rd_addr = {rd_a[1], rd_a[0]};
    assign b_rd_addr = {rd_a[3][3:0], rd_a[2][3:0], rd_a[1][3:0], rd_a[0][3:0]};

    banco_registros_param #(.DATA_W(32), .NUM_REGS(32), .NUM_READ(2)) dut_a (
        .clock(clock), .reset(reset),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[31:0]), .wr_be(wr_be[3:0]),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_count(a_busy_count), .rsv_err(a_rsv_err)
    );

    banco_registros_param #(.DATA_W(64), .NUM_REGS(16), .NUM_READ(4)) dut_b (
        .clock(clock), .reset(reset),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr[3:0]), .wr_data(wr_data), .wr_be(wr_be),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr[3:0]),
        .busy_count(b_busy_count), .rsv_err(b_rsv_err)
    );

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t        sbq [$];
    int          checks = 0;
    int          errors = 0;

    logic [63:0] m_a [32];
    logic [63:0] m_b [16];
    logic [31:0] bz_a;
    logic [15:0] bz_b;
    logic        e_a;
    logic        e_b;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] be, input int nb);
        logic [63:0] r = old;
        for (int b = 0; b < nb; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] exp_a_data(input int k);
        logic [4:0] a = rd_a[k];
        if (!reset || a == 5'd0) return '0;
        if (wr_en && wr_addr == a) return merge(m_a[a], wr_data, wr_be, 4);
        return m_a[a];
    endfunction

    function automatic logic [63:0] exp_b_data(input int k);
        logic [3:0] a = rd_a[k][3:0];
        if (!reset || a == 4'd0) return '0;
        if (wr_en && wr_addr[3:0] == a) return merge(m_b[a], wr_data, wr_be, 8);
        return m_b[a];
    endfunction

    function automatic logic exp_a_busy(input int k);
        logic [4:0] a = rd_a[k];
        return reset && a != 5'd0 && bz_a[a] && !(wr_en && wr_addr == a);
    endfunction

    function automatic logic exp_b_busy(input int k);
        logic [3:0] a = rd_a[k][3:0];
        return reset && a != 4'd0 && bz_b[a] && !(wr_en && wr_addr[3:0] == a);
    endfunction

    task automatic push(input string tag, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic chk(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic set_reset(input logic v);
        reset = v;
        if (!v) begin
            for (int i = 0; i < 32; i++) m_a[i] = '0;
            for (int i = 0; i < 16; i++) m_b[i] = '0;
            bz_a = '0;
            bz_b = '0;
            e_a  = 1'b0;
            e_b  = 1'b0;
        end
    endtask

    // Applies the write/reserve rules to the model using the inputs held across the edge.
    task automatic model_edge();
        logic [4:0] wa;
        logic [4:0] ra;
        logic [3:0] wb;
        logic [3:0] rb;
        logic       wv;
        logic       rv;
        if (!reset) begin
            set_reset(1'b0);
            return;
        end
        wa = wr_addr;
        ra = rsv_addr;
        wv = wr_en && wa != 5'd0;
        rv = rsv_en && ra != 5'd0;
        if (rv && bz_a[ra] && !(wv && wa == ra)) e_a = 1'b1;
        if (wv) begin
            m_a[wa]  = merge(m_a[wa], wr_data, wr_be, 4);
            bz_a[wa] = 1'b0;
        end
        if (rv) bz_a[ra] = 1'b1;
        wb = wr_addr[3:0];
        rb = rsv_addr[3:0];
        wv = wr_en && wb != 4'd0;
        rv = rsv_en && rb != 4'd0;
        if (rv && bz_b[rb] && !(wv && wb == rb)) e_b = 1'b1;
        if (wv) begin
            m_b[wb]  = merge(m_b[wb], wr_data, wr_be, 8);
            bz_b[wb] = 1'b0;
        end
        if (rv) bz_b[rb] = 1'b1;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic check_now();
        for (int k = 0; k < 2; k++) begin
            push($sformatf("A_rd_data%0d", k), exp_a_data(k));
            push($sformatf("A_rd_busy%0d", k), 64'(exp_a_busy(k)));
        end
        push("A_busy_count", 64'($countones(bz_a)));
        push("A_rsv_err", 64'(e_a));
        for (int k = 0; k < 4; k++) begin
            push($sformatf("B_rd_data%0d", k), exp_b_data(k));
            push($sformatf("B_rd_busy%0d", k), 64'(exp_b_busy(k)));
        end
        push("B_busy_count", 64'($countones(bz_b)));
        push("B_rsv_err", 64'(e_b));
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(64'(a_rd_data[k*32 +: 32]));
            chk(64'(a_rd_busy[k]));
        end
        chk(64'(a_busy_count));
        chk(64'(a_rsv_err));
        for (int k = 0; k < 4; k++) begin
            chk(b_rd_data[k*64 +: 64]);
            chk(64'(b_rd_busy[k]));
        end
        chk(64'(b_busy_count));
        chk(64'(b_rsv_err));
    endtask

    task automatic lit(input string tag, input logic [63:0] exp, input logic [63:0] obs);
        push(tag, exp);
        chk(obs);
    endtask

    task automatic rd_all(input logic [4:0] a);
        for (int k = 0; k < 4; k++) rd_a[k] = a;
    endtask

    initial begin
        set_reset(1'b0);
        #3;
        check_now();
        #3;
        set_reset(1'b1);
        @(posedge clock);
        #1;

        // Byte-enable merge on r5
        rd_all(5'd5);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h0123_4567_DEAD_BEEF; wr_be = 8'hFF;
        check_now();
        tick();
        wr_data = 64'h0000_0000_0000_00AA; wr_be = 8'h01;
        check_now();
        lit("A_fwd_merge", 64'hDEAD_BEAA, 64'(a_rd_data[31:0]));
        tick();
        wr_en = 1'b0;
        check_now();
        lit("A_r5_p1", 64'hDEAD_BEAA, 64'(a_rd_data[63:32]));
        lit("B_r5_p3", 64'h0123_4567_DEAD_BEAA, b_rd_data[255:192]);

        // Forwarding to several ports, then writes to r0 are dropped
        rd_all(5'd7);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h1234_5678; wr_be = 8'hFF;
        check_now();
        lit("A_fwd_p0", 64'h1234_5678, 64'(a_rd_data[31:0]));
        lit("A_fwd_p1", 64'h1234_5678, 64'(a_rd_data[63:32]));
        tick();
        rd_all(5'd0);
        wr_addr = 5'd0; wr_data = '1;
        check_now();
        tick();
        wr_en = 1'b0;
        check_now();

        // Reservations and clearing by write
        rsv_en = 1'b1; rsv_addr = 5'd3;
        tick();
        rsv_addr = 5'd4;
        tick();
        rsv_en = 1'b0;
        rd_a[0] = 5'd3; rd_a[1] = 5'd4; rd_a[2] = 5'd3; rd_a[3] = 5'd4;
        check_now();
        lit("A_count_2", 64'd2, 64'(a_busy_count));
        lit("A_busy_r3", 64'd1, 64'(a_rd_busy[0]));
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h33; wr_be = 8'hFF;
        check_now();
        tick();
        wr_en = 1'b0;
        check_now();
        lit("B_count_1", 64'd1, 64'(b_busy_count));

        // Reserve and write the same register, then re-reserve it
        rd_all(5'd9);
        rsv_en = 1'b1; rsv_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h9999_0000_0000_9999; wr_be = 8'hFF;
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
        check_now();
        rsv_en = 1'b1;
        tick();
        rsv_en = 1'b0;
        check_now();
        lit("A_err_set", 64'd1, 64'(a_rsv_err));
        lit("A_count_after_err", 64'd2, 64'(a_busy_count));

        // Empty byte enable clears busy but keeps data
        rsv_en = 1'b1; rsv_addr = 5'd5;
        tick();
        rsv_en = 1'b0;
        rd_all(5'd5);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = '1; wr_be = 8'h00;
        check_now();
        tick();
        wr_en = 1'b0;
        check_now();

        // Fill every register, reserve a few, then reset between edges
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_be = 8'hFF;
            wr_data = {32'hC0DE_0000 | 32'(i), 32'h5A00_0000 | 32'(i)};
            tick();
        end
        wr_en = 1'b0;
        rsv_en = 1'b1;
        for (int i = 10; i < 13; i++) begin
            rsv_addr = 5'(i);
            tick();
        end
        rsv_en = 1'b0;
        rd_a[0] = 5'd10; rd_a[1] = 5'd20; rd_a[2] = 5'd31; rd_a[3] = 5'd1;
        check_now();
        #2;
        set_reset(1'b0);
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 64'h66; wr_be = 8'hFF;
        rsv_en = 1'b1; rsv_addr = 5'd6;
        rd_a[1] = 5'd6;
        check_now();
        tick();
        check_now();
        #2;
        set_reset(1'b1);
        wr_en = 1'b0; rsv_en = 1'b0;
        check_now();
        lit("A_r6_discarded", 64'd0, 64'(a_rd_data[63:32]));

        // First edge after release behaves normally
        wr_en = 1'b1; rsv_en = 1'b1;
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
        rd_all(5'd6);
        check_now();
        lit("B_r6_after_reset", 64'h66, b_rd_data[63:0]);

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
